// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream in, instruction RAM write port and boot status out
interface imem_boot_loader_if #(
    parameter int IWIDTH = 11
);
    logic              load_req;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [IWIDTH-1:0] im_wadr;
    logic [31:0]       im_wdata;
    logic              im_we;
    logic              cpu_start;
    logic              busy;
    logic              done;
    logic              err;
    modport master (
        output load_req, rx_data, rx_valid,
        input  im_wadr, im_wdata, im_we, cpu_start, busy, done, err
    );
    modport slave (
        input  load_req, rx_data, rx_valid,
        output im_wadr, im_wdata, im_we, cpu_start, busy, done, err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed UART image into instruction RAM, then pulses cpu_start; `IMEM_BOOT_LOADER_CSUM_EN adds the checksum byte
module imem_boot_loader #(
    parameter int          IWIDTH = 11,
    parameter logic [23:0] TO_CYC = 24'd1000000
) (
    input logic               clk,
    input logic               rst,
    imem_boot_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, START, ERR} state_t;
    localparam logic [16:0] CAP = 17'(1) << IWIDTH;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
    localparam state_t TAIL = CSUM;
    logic [7:0] sum;
`else
    localparam state_t TAIL = START;
`endif
    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       rem;
    logic [1:0]        lane;
    logic [23:0]       asm_word;
    logic [IWIDTH-1:0] wptr;
    logic [23:0]       tmr;
    logic [16:0]       n_len;
    assign n_len = {1'b0, bus.rx_data, len_lo};
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len_lo        <= '0;
            rem           <= '0;
            lane          <= '0;
            asm_word      <= '0;
            wptr          <= '0;
            tmr           <= TO_CYC;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
            sum           <= '0;
`endif
            bus.im_wadr   <= '0;
            bus.im_wdata  <= '0;
            bus.im_we     <= 1'b0;
            bus.cpu_start <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.im_we     <= 1'b0;
            bus.cpu_start <= 1'b0;
            case (state)
                IDLE, ERR: if (bus.load_req) begin
                    state    <= LEN0;
                    bus.busy <= 1'b1;
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    tmr      <= TO_CYC;
                    lane     <= '0;
                    wptr     <= '0;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
                    sum      <= '0;
`endif
                end
                START: begin
                    bus.cpu_start <= 1'b1;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: if (bus.rx_valid) begin
                    tmr <= TO_CYC;
                    case (state)
                        LEN0: begin
                            len_lo <= bus.rx_data;
                            state  <= LEN1;
                        end
                        LEN1: begin
                            rem <= n_len[15:0];
                            if (n_len > CAP) begin
                                state    <= ERR;
                                bus.err  <= 1'b1;
                                bus.busy <= 1'b0;
                            end else state <= (n_len == 17'd0) ? TAIL : DATA;
                        end
                        DATA: begin
                            lane <= lane + 2'd1;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
                            sum  <= sum + bus.rx_data;
`endif
                            if (lane != 2'd3) asm_word[{lane, 3'b000} +: 8] <= bus.rx_data;
                            else begin
                                bus.im_we    <= 1'b1;
                                bus.im_wadr  <= wptr;
                                bus.im_wdata <= {bus.rx_data, asm_word};
                                wptr         <= wptr + 1'b1;
                                rem          <= rem - 16'd1;
                                if (rem == 16'd1) state <= TAIL;
                            end
                        end
`ifdef IMEM_BOOT_LOADER_CSUM_EN
                        CSUM: if (bus.rx_data == sum) state <= START;
                        else begin
                            state    <= ERR;
                            bus.err  <= 1'b1;
                            bus.busy <= 1'b0;
                        end
`endif
                        default: ;
                    endcase
                end else if (tmr == 24'd1) begin
                    state    <= ERR;
                    bus.err  <= 1'b1;
                    bus.busy <= 1'b0;
                end else tmr <= tmr - 24'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized frame loads scored against expected RAM writes and start pulses
module tb_imem_boot_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    imem_boot_loader_if #(.IWIDTH(2)) bus ();
    imem_boot_loader #(.IWIDTH(2), .TO_CYC(24'd16)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        int          adr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t wq[$];
    int  sq[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cyc %0d", nm, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (bus.im_we) begin
            if (wq.size() == 0) check("unexpected_write", {30'd0, bus.im_wadr}, 32'hffffffff);
            else begin
                wr_t e;
                e = wq.pop_front();
                check("wr_adr", {30'd0, bus.im_wadr}, e.adr);
                check("wr_data", bus.im_wdata, e.data);
                check("wr_cyc", cyc, e.cyc);
            end
        end
        if (bus.cpu_start) begin
            if (sq.size() == 0) check("unexpected_start", cyc, 32'hffffffff);
            else check("start_cyc", cyc, sq.pop_front());
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_req();
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask
    // idle gaps mid-frame, occasionally carrying a load_req that must be ignored
    task automatic gap();
        repeat ($urandom_range(0, 3)) begin
            bus.load_req = ($urandom_range(0, 7) == 0);
            tick();
            bus.load_req = 1'b0;
        end
    endtask
    task automatic check_reset_vals();
        check("rst_wadr", {30'd0, bus.im_wadr}, 0);
        check("rst_wdata", bus.im_wdata, 0);
        check("rst_we", {31'd0, bus.im_we}, 0);
        check("rst_start", {31'd0, bus.cpu_start}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_err", {31'd0, bus.err}, 0);
    endtask
    task automatic run_frame(input logic [31:0] ws[$], input bit corrupt, input bit req);
        logic [7:0] s;
        int         n;
        int         d;
        bit         good;
        s = 8'd0;
        n = ws.size();
        if (req) pulse_req();
        send_byte(8'(n));
        gap();
        d = cyc;
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                gap();
                d = cyc;
                send_byte(ws[i][8*b +: 8]);
                s = s + ws[i][8*b +: 8];
                if (b == 3) wq.push_back('{i % 4, ws[i], d + 1});
            end
        end
`ifdef IMEM_BOOT_LOADER_CSUM_EN
        gap();
        d = cyc;
        send_byte(corrupt ? s + 8'd1 : s);
        good = !corrupt;
`else
        good = 1'b1;
`endif
        if (good) sq.push_back(d + 2);
        repeat (3) tick();
        check("done", {31'd0, bus.done}, {31'd0, good});
        check("err", {31'd0, bus.err}, {31'd0, !good});
        check("busy_end", {31'd0, bus.busy}, 0);
        check("writes_pending", wq.size(), 0);
        check("starts_pending", sq.size(), 0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] ws[$];
        logic [31:0] w0;
        logic [31:0] w1;
        int          d;
        bus.load_req = 1'b0;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;
        tick();
        ws = '{32'h00000013, 32'h0000006f};
        run_frame(ws, 1'b0, 1'b1);
`ifdef IMEM_BOOT_LOADER_CSUM_EN
        run_frame(ws, 1'b1, 1'b1);
        pulse_req();
        check("err_cleared", {31'd0, bus.err}, 0);
        check("busy_len0", {31'd0, bus.busy}, 1);
        run_frame(ws, 1'b0, 1'b0);
`endif
        pulse_req();
        send_byte(8'h05);
        send_byte(8'h00);
        tick();
        check("ovf_err", {31'd0, bus.err}, 1);
        check("ovf_busy", {31'd0, bus.busy}, 0);
        ws = '{$urandom, $urandom, $urandom, $urandom};
        run_frame(ws, 1'b0, 1'b1);
        pulse_req();
        send_byte(8'h01);
        repeat (14) tick();
        check("to_early_err", {31'd0, bus.err}, 0);
        check("to_early_busy", {31'd0, bus.busy}, 1);
        repeat (2) tick();
        check("to_err", {31'd0, bus.err}, 1);
        check("to_busy", {31'd0, bus.busy}, 0);
        ws = '{};
        run_frame(ws, 1'b0, 1'b1);
        w0 = $urandom;
        w1 = $urandom;
        pulse_req();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int b = 0; b < 4; b++) begin
            d = cyc;
            send_byte(w0[8*b +: 8]);
            if (b == 3) wq.push_back('{0, w0, d + 1});
        end
        send_byte(w1[7:0]);
        send_byte(w1[15:8]);
        rst = 1'b1;
        tick();
        check_reset_vals();
        tick();
        rst = 1'b0;
        send_byte(w1[23:16]);
        send_byte(w1[31:24]);
        repeat (2) tick();
        check("midrst_busy", {31'd0, bus.busy}, 0);
        ws = '{$urandom, $urandom};
        run_frame(ws, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
            ws = '{};
            repeat ($urandom_range(0, 4)) ws.push_back($urandom);
            run_frame(ws, $urandom_range(0, 4) == 0, 1'b1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
